// File: rtl/timer_pkg.sv
// Shared types and default sizes for the 8-bit down-counter timer.
package timer_pkg;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/prescaler_tick.sv
// Clock-enable prescaler: strobes tick once every prescale+1 enabled cycles.
module prescaler_tick #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (reload) begin
      presc_d = prescale;
    end else if (en) begin
      if (presc_q == '0) begin
        tick    = 1'b1;
        presc_d = prescale;
      end else begin
        presc_d = presc_q - PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/down_counter_timer8.sv
// Programmable down-counter/timer with prescaler, one-shot/auto-reload and sticky done.
//   state | meaning
//   IDLE  | loaded or stopped, not counting
//   RUN   | counting down on prescaler ticks
//   DONE  | one-shot reached zero, holds until load/start
module down_counter_timer8
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_done,
  input  logic                  oe,
  output logic [WIDTH-1:0]      count_out,
  output logic                  tc_pulse,
  output logic                  done,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             tick;

  prescaler_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (en && (state_q == RUN)),
    .reload   (load || start),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    if (clr_done) done_d = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      done_d   = 1'b0;
      state_d  = IDLE;
    end else if (start) begin
      count_d = reload_q;
      done_d  = 1'b0;
      state_d = (reload_q != '0) ? RUN : IDLE;
    end else if ((state_q == RUN) && tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        // terminal count: a coincident clr_done loses to the set
        tc_d   = 1'b1;
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign count_out = oe ? count_q : '0;
  assign tc_pulse  = tc_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);

endmodule
